aes_sbox_array: RTL and testbench

AES_SBOX_ARRAY -- requirements
Module: aes_sbox_array

---
 rtl/aes_sbox_array.sv | 146 ++++++++++++++
 tb/tb_aes_sbox_array.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_array.sv
// aes_sbox_array: applies the AES S-box (or its inverse) to every byte of a
// transaction, NSBOX bytes per clock, using a small valid/ready FSM.
// Each lane computes the GF(2^8) inverse algebraically and wraps it with the
// forward or inverse affine layer, so one inverter serves both directions.
module aes_sbox_array #(
    parameter int NBYTES = 16,
    parameter int NSBOX  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_decode,
    input  logic [8*NBYTES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_data,
    output logic                  out_decode,
    output logic                  busy
);

    localparam int NBEATS = NBYTES / NSBOX;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int IW     = (NBYTES > 1) ? $clog2(8 * NBYTES) : 3;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    state_t              state_next;
    logic [BW-1:0]       beat;
    logic [8*NBYTES-1:0] work;
    logic [8*NBYTES-1:0] work_next;
    logic                mode;
    logic                accept;
    logic [IW-1:0]       lane_lsb [NSBOX];

    // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse; zero maps to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    // Forward: affine(inv(x)); inverse: inv(inverse_affine(x)).
    function automatic logic [7:0] sbox_lane(input logic [7:0] x, input logic dec);
        logic [7:0] g;
        g = gf_inv(dec ? affine_inv(x) : x);
        return dec ? g : affine_fwd(g);
    endfunction

    assign accept     = in_valid && in_ready;
    assign out_data   = work;
    assign out_decode = mode;
    assign busy       = (state != IDLE);

    // Handshake outputs and next state for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                if (beat == LAST_BEAT) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_next = in_valid ? BUSY : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bit offset of each lane's byte within the working register for this beat.
    always_comb begin
        for (int j = 0; j < NSBOX; j++) begin
            lane_lsb[j] = IW'((int'(beat) * NSBOX + j) * 8);
        end
    end

    // Substitute the current beat's bytes; all other bytes pass through.
    always_comb begin
        work_next = work;
        for (int j = 0; j < NSBOX; j++) begin
            work_next[lane_lsb[j] +: 8] = sbox_lane(work[lane_lsb[j] +: 8], mode);
        end
    end

    // State, beat counter, working register and latched mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
            work  <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                work <= in_data;
                mode <= in_decode;
                beat <= '0;
            end else if (state == BUSY) begin
                work <= work_next;
                if (beat != LAST_BEAT) beat <= beat + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_aes_sbox_array.sv
// tb_aes_sbox_array: directed checks of aes_sbox_array in three geometries
// (16,4), (16,16) and (4,1) against a FIPS-197 S-box lookup table.
// Latency is counted in rising edges from the cycle the transaction is offered.
module tb_aes_sbox_array;

    logic clk;
    logic rst;

    logic         in_valid  [3];
    logic         in_decode [3];
    logic         out_ready [3];
    logic [127:0] in_data   [3];

    logic         in_ready0, out_valid0, out_decode0, busy0;
    logic         in_ready1, out_valid1, out_decode1, busy1;
    logic         in_ready2, out_valid2, out_decode2, busy2;
    logic [127:0] out_data0, out_data1;
    logic [31:0]  out_data2;

    logic [2047:0] sbox_flat;
    logic [7:0]    inv_tab [256];

    int checks;
    int fails;

    aes_sbox_array #(.NBYTES(16), .NSBOX(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready0), .in_decode(in_decode[0]),
        .in_data(in_data[0]), .out_valid(out_valid0), .out_ready(out_ready[0]),
        .out_data(out_data0), .out_decode(out_decode0), .busy(busy0)
    );

    aes_sbox_array #(.NBYTES(16), .NSBOX(16)) u_wide (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready1), .in_decode(in_decode[1]),
        .in_data(in_data[1]), .out_valid(out_valid1), .out_ready(out_ready[1]),
        .out_data(out_data1), .out_decode(out_decode1), .busy(busy1)
    );

    aes_sbox_array #(.NBYTES(4), .NSBOX(1)) u_narrow (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready2), .in_decode(in_decode[2]),
        .in_data(in_data[2][31:0]), .out_valid(out_valid2), .out_ready(out_ready[2]),
        .out_data(out_data2), .out_decode(out_decode2), .busy(busy2)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] fwd(input int b);
        return sbox_flat[8 * (255 - b) +: 8];
    endfunction

    function automatic logic sel_valid(input int w);
        case (w)
            0:       return out_valid0;
            1:       return out_valid1;
            default: return out_valid2;
        endcase
    endfunction

    function automatic logic sel_decode(input int w);
        case (w)
            0:       return out_decode0;
            1:       return out_decode1;
            default: return out_decode2;
        endcase
    endfunction

    function automatic logic [127:0] sel_data(input int w);
        case (w)
            0:       return out_data0;
            1:       return out_data1;
            default: return {96'h0, out_data2};
        endcase
    endfunction

    // One comparison: count it, and on mismatch count and report it.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one transaction to DUT w (out_ready assumed high), scramble the
    // inputs after the accept edge, and wait (bounded) for the result.
    task automatic applyStimulus(input int w, input logic [127:0] data, input logic dec,
                                 output logic [127:0] res, output logic rdec, output int lat);
        @(negedge clk);
        in_valid[w]  = 1'b1;
        in_data[w]   = data;
        in_decode[w] = dec;
        @(negedge clk);
        in_valid[w]  = 1'b0;
        in_data[w]   = ~data;
        in_decode[w] = ~dec;
        lat = 1;
        while (!sel_valid(w) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res  = sel_data(w);
        rdec = sel_decode(w);
    endtask

    initial begin
        logic [127:0] res;
        logic [127:0] res2;
        logic         rdec;
        int           lat;
        int           seen;
        int           nb;
        int           elat;
        logic [127:0] d;
        logic [127:0] ef;
        logic [127:0] ei;

        checks = 0;
        fails  = 0;
        sbox_flat = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int x = 0; x < 256; x++) inv_tab[fwd(x)] = 8'(x);

        rst = 1'b1;
        for (int w = 0; w < 3; w++) begin
            in_valid[w]  = 1'b0;
            in_decode[w] = 1'b0;
            in_data[w]   = '0;
            out_ready[w] = 1'b1;
        end

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready",   128'(in_ready0),   128'(1));
        checkOutput("rst_out_valid",  128'(out_valid0),  128'(0));
        checkOutput("rst_busy",       128'(busy0),       128'(0));
        checkOutput("rst_out_data",   out_data0,         128'h0);
        checkOutput("rst_out_decode", 128'(out_decode0), 128'(0));
        checkOutput("rst_wide_busy",  128'(busy1),       128'(0));
        checkOutput("rst_narrow_rdy", 128'(in_ready2),   128'(1));
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready",  128'(in_ready0),   128'(1));

        // Directed forward / inverse vectors
        applyStimulus(0, {16{8'h00}}, 1'b0, res, rdec, lat);
        checkOutput("zero_fwd_data", res, {16{8'h63}});
        checkOutput("zero_fwd_dec",  128'(rdec), 128'(0));
        checkOutput("zero_fwd_lat",  128'(lat),  128'(5));

        applyStimulus(0, {16{8'h63}}, 1'b1, res, rdec, lat);
        checkOutput("63_inv_data", res, {16{8'h00}});
        checkOutput("63_inv_dec",  128'(rdec), 128'(1));
        checkOutput("63_inv_lat",  128'(lat),  128'(5));

        applyStimulus(0, {{13{8'h01}}, 8'h00, 8'hFF, 8'h53}, 1'b0, res, rdec, lat);
        checkOutput("mix_fwd_data", res, {{13{8'h7C}}, 8'h63, 8'h16, 8'hED});

        applyStimulus(0, {{13{8'h63}}, 8'h16, 8'h00, 8'hED}, 1'b1, res, rdec, lat);
        checkOutput("mix_inv_data", res, {{13{8'h00}}, 8'hFF, 8'h52, 8'h53});

        applyStimulus(1, {16{8'h00}}, 1'b1, res, rdec, lat);
        checkOutput("wide_inv_data", res, {16{8'h52}});
        checkOutput("wide_lat",      128'(lat), 128'(2));

        // Backpressure in DONE, then back-to-back accept
        out_ready[0] = 1'b0;
        @(negedge clk);
        in_valid[0]  = 1'b1;
        in_data[0]   = {8{8'h53, 8'h00}};
        in_decode[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        checkOutput("bp_busy_flag",  128'(busy0),     128'(1));
        checkOutput("bp_busy_ready", 128'(in_ready0), 128'(0));
        lat = 1;
        while (!out_valid0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_lat",  128'(lat), 128'(5));
        checkOutput("bp_data", out_data0, {8{8'hED, 8'h63}});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_hold_valid_%0d", i), 128'(out_valid0), 128'(1));
            checkOutput($sformatf("bp_hold_data_%0d", i),  out_data0, {8{8'hED, 8'h63}});
            checkOutput($sformatf("bp_hold_ready_%0d", i), 128'(in_ready0),  128'(0));
        end
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = {16{8'hFF}};
        in_decode[0] = 1'b0;
        #1;
        checkOutput("b2b_in_ready", 128'(in_ready0), 128'(1));
        @(negedge clk);
        in_valid[0] = 1'b0;
        checkOutput("b2b_no_bubble_valid", 128'(out_valid0), 128'(0));
        checkOutput("b2b_no_bubble_busy",  128'(busy0),      128'(1));
        checkOutput("b2b_no_bubble_ready", 128'(in_ready0),  128'(0));
        lat = 1;
        while (!out_valid0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("b2b_lat",  128'(lat), 128'(5));
        checkOutput("b2b_data", out_data0, {16{8'h16}});

        // Reset in the second BUSY cycle abandons the transaction
        @(negedge clk);
        in_valid[0]  = 1'b1;
        in_data[0]   = {16{8'h11}};
        in_decode[0] = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_in_ready",  128'(in_ready0),  128'(1));
        checkOutput("midrst_out_valid", 128'(out_valid0), 128'(0));
        checkOutput("midrst_busy",      128'(busy0),      128'(0));
        checkOutput("midrst_data",      out_data0,        128'h0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid0) seen++;
        end
        checkOutput("midrst_no_result", 128'(seen), 128'(0));

        // Full 256-value sweep in both modes for each geometry
        for (int w = 0; w < 3; w++) begin
            nb   = (w == 2) ? 4 : 16;
            elat = (w == 1) ? 2 : 5;
            for (int c = 0; c < 256 / nb; c++) begin
                d  = '0;
                ef = '0;
                ei = '0;
                for (int i = 0; i < nb; i++) begin
                    d[8*i +: 8]  = 8'(c * nb + i);
                    ef[8*i +: 8] = fwd(c * nb + i);
                    ei[8*i +: 8] = inv_tab[c * nb + i];
                end
                applyStimulus(w, d, 1'b0, res, rdec, lat);
                checkOutput($sformatf("sweep_fwd_w%0d_c%0d", w, c), res, ef);
                checkOutput($sformatf("sweep_fwd_lat_w%0d_c%0d", w, c), 128'(lat), 128'(elat));
                applyStimulus(w, res, 1'b1, res2, rdec, lat);
                checkOutput($sformatf("sweep_roundtrip_w%0d_c%0d", w, c), res2, d);
                checkOutput($sformatf("sweep_rt_dec_w%0d_c%0d", w, c), 128'(rdec), 128'(1));
                applyStimulus(w, d, 1'b1, res, rdec, lat);
                checkOutput($sformatf("sweep_inv_w%0d_c%0d", w, c), res, ei);
                checkOutput($sformatf("sweep_inv_lat_w%0d_c%0d", w, c), 128'(lat), 128'(elat));
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
